// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS mult/multu/div/divu unit owning the HI/LO registers
// Optional MULDIV_EARLY_TERM_EN: multiplies finish once the remaining multiplier magnitude is zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   divisor;

    logic               sgn;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               zero_div;
    logic               mul_last;
    logic               div_last;
    logic [WIDTH:0]     part;
    logic               part_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign sgn      = ~op[0];
    assign mag1     = (sgn && in1[WIDTH-1]) ? -in1 : in1;
    assign mag2     = (sgn && in2[WIDTH-1]) ? -in2 : in2;
    assign zero_div = op[1] && (in2 == '0);

`ifdef MULDIV_EARLY_TERM_EN
    assign mul_last = (mplier[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt == CW'(WIDTH - 1));
`endif
    assign div_last = (cnt == CW'(WIDTH - 1));

    // Restoring step: when the trial subtraction fits, the W-bit wraparound
    // difference is exact because the true remainder is below the divisor.
    assign part     = {rem, quo[WIDTH-1]};
    assign part_ge  = (part >= {1'b0, divisor});
    assign rem_next = part_ge ? (part[WIDTH-1:0] - divisor) : part[WIDTH-1:0];

    assign prod   = neg_lo ? -acc : acc;
    assign res_hi = is_div ? (neg_hi ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div ? (neg_lo ? -quo : quo) : prod[WIDTH-1:0];

    assign busy = (state == S_MUL) || (state == S_DIV);
    assign done = (state == S_FIN) && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        div_zero <= zero_div;
                        is_div   <= op[1];
                        cnt      <= '0;
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, mag1};
                        mplier   <= mag2;
                        divisor  <= mag2;
                        if (zero_div) begin
                            // FIN then publishes rem/quo unchanged: hi=in1, lo=all ones
                            rem    <= in1;
                            quo    <= '1;
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                            state  <= S_FIN;
                        end else begin
                            rem    <= '0;
                            quo    <= mag1;
                            neg_lo <= sgn & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                            neg_hi <= op[1] & sgn & in1[WIDTH-1];
                            state  <= op[1] ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                        if (mul_last) state <= S_FIN;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= rem_next;
                        quo <= {quo[WIDTH-2:0], part_ge};
                        cnt <= cnt + CW'(1);
                        if (div_last) state <= S_FIN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, start, flush, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] in1, in2, wdata;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_hi, exp_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
        logic signed [2*W-1:0] sa, sb, sr;
        logic [2*W-1:0] ur;
        sa = $signed({{W{a[W-1]}}, a});
        sb = $signed({{W{b[W-1]}}, b});
        if (o[1] && b == '0) begin
            h = a;
            l = '1;
        end else begin
            case (o)
                2'd0: begin sr = sa * sb; h = sr[2*W-1:W]; l = sr[W-1:0]; end
                2'd1: begin ur = {{W{1'b0}}, a} * {{W{1'b0}}, b}; h = ur[2*W-1:W]; l = ur[W-1:0]; end
                2'd2: begin sr = sa / sb; l = sr[W-1:0]; sr = sa % sb; h = sr[W-1:0]; end
                default: begin l = a / b; h = a % b; end
            endcase
        end
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [W-1:0] b);
        logic [W-1:0] m;
        m = (!o[0] && b[W-1]) ? -b : b;
        if (o[1]) return (b == '0) ? 1 : W + 1;
`ifdef MULDIV_EARLY_TERM_EN
        if (m == '0) return 2;
        for (int i = W - 1; i >= 0; i--)
            if (m[i]) return i + 2;
`endif
        return (m == m) ? W + 1 : 0;
    endfunction

    // Launches one operation and reports what the DUT did; comparisons live in the callers.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic shape_ok,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        op = o; in1 = a; in2 = b; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        shape_ok = 1'b1;
        for (int c = 1; c <= W + 8; c++) begin
            if (done) begin
                lat = c;
                if (busy) shape_ok = 1'b0;
                break;
            end
            if (!busy) shape_ok = 1'b0;
            step();
        end
        step();
        if (done || busy) shape_ok = 1'b0;
        h = hi;
        l = lo;
        dz = div_zero;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; in1 = '0; in2 = '0; wdata = '0;
        step(); step();
        rst_n = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom | 32'h1;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd2; in1 = $urandom; in2 = 32'h0; start = 1'b1;
        step();
        rst_n = 1'b0; op = 2'd1; in1 = $urandom; in2 = $urandom;
        step(); step();
        rst_n = 1'b1; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
        begin
            logic active = 1'b0;
            repeat (40) begin
                if (busy || done) active = 1'b1;
                step();
            end
            checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_discard got activity=%b want 0", active); end
        end
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_mult;
        logic [1:0] qo[$];
        logic [W-1:0] qa[$], qb[$];
        logic [W-1:0] eh, el, h, l;
        logic ok, dz;
        int lat;
        qo = {2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        qa = {32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'h0000_0009};
        qb = {32'h00000007, 32'h00000007, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h0000_0001};
        for (int i = 0; i < 14; i++) begin
            qo.push_back({1'b0, 1'($urandom_range(0, 1))});
            qa.push_back($urandom);
            qb.push_back($urandom >> $urandom_range(0, 31));
        end
        for (int i = 0; i < qo.size(); i++) begin
            model(qo[i], qa[i], qb[i], eh, el);
            do_op(qo[i], qa[i], qb[i], lat, ok, h, l, dz);
            checks++; if (lat !== exp_latency(qo[i], qb[i])) begin errors++;
                $display("FAIL mult_latency op=%0d a=%h b=%h got %0d want %0d", qo[i], qa[i], qb[i], lat, exp_latency(qo[i], qb[i])); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mult_busy_done_shape op=%0d got %b want 1", qo[i], ok); end
            checks++; if (h !== eh) begin errors++; $display("FAIL mult_hi op=%0d a=%h b=%h got %h want %h", qo[i], qa[i], qb[i], h, eh); end
            checks++; if (l !== el) begin errors++; $display("FAIL mult_lo op=%0d a=%h b=%h got %h want %h", qo[i], qa[i], qb[i], l, el); end
            checks++; if (dz !== 1'b0) begin errors++; $display("FAIL mult_div_zero got %b want 0", dz); end
            exp_hi = eh;
            exp_lo = el;
        end
    endtask

    task automatic test_div;
        logic [1:0] qo[$];
        logic [W-1:0] qa[$], qb[$];
        logic [W-1:0] eh, el, h, l, b;
        logic ok, dz, edz;
        int lat;
        qo = {2'd2, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
        qa = {32'hFFFFFFF9, 32'h80000000, 32'd100, 32'd7, 32'd5, 32'h00001234, 32'hFFFFFFFF, 32'hFFFFFFF9};
        qb = {32'h00000002, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE, 32'd10, 32'h0, 32'h1, 32'hFFFFFFFE};
        for (int i = 0; i < 12; i++) begin
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) b = '0;
            qo.push_back({1'b1, 1'($urandom_range(0, 1))});
            qa.push_back($urandom);
            qb.push_back(b);
        end
        qo.push_back(2'd1); qa.push_back(32'd2); qb.push_back(32'd3);
        for (int i = 0; i < qo.size(); i++) begin
            model(qo[i], qa[i], qb[i], eh, el);
            edz = qo[i][1] && (qb[i] == '0);
            do_op(qo[i], qa[i], qb[i], lat, ok, h, l, dz);
            checks++; if (lat !== exp_latency(qo[i], qb[i])) begin errors++;
                $display("FAIL div_latency op=%0d a=%h b=%h got %0d want %0d", qo[i], qa[i], qb[i], lat, exp_latency(qo[i], qb[i])); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL div_busy_done_shape op=%0d b=%h got %b want 1", qo[i], qb[i], ok); end
            checks++; if (h !== eh) begin errors++; $display("FAIL div_hi op=%0d a=%h b=%h got %h want %h", qo[i], qa[i], qb[i], h, eh); end
            checks++; if (l !== el) begin errors++; $display("FAIL div_lo op=%0d a=%h b=%h got %h want %h", qo[i], qa[i], qb[i], l, el); end
            checks++; if (dz !== edz) begin errors++; $display("FAIL div_zero_flag op=%0d b=%h got %b want %b", qo[i], qb[i], dz, edz); end
            exp_hi = eh;
            exp_lo = el;
        end
    endtask

    task automatic test_flush;
        logic active;
        logic [W-1:0] v;
        op = 2'd0; in1 = 32'd5; in2 = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b want 1", busy); end
        start = 1'b1; hi_we = 1'b1; wdata = 32'hAA; flush = 1'b1;
        step();
        start = 1'b0; hi_we = 1'b0; flush = 1'b0;
        active = 1'b0;
        repeat (40) begin
            if (busy || done) active = 1'b1;
            step();
        end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL flush_idle got activity=%b want 0", active); end
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL flush_hi_hold got %h want %h", hi, exp_hi); end
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL flush_lo_hold got %h want %h", lo, exp_lo); end
        lo_we = 1'b1; wdata = 32'h55;
        step();
        lo_we = 1'b0;
        exp_lo = 32'h55;
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL mtlo_lo got %h want %h", lo, exp_lo); end
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL mtlo_hi_hold got %h want %h", hi, exp_hi); end
        v = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = v;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        exp_hi = v; exp_lo = v;
        checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL mthi_mtlo_both got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
        op = 2'd1; in1 = 32'd3; in2 = 32'd3; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_flush_drops_start got busy,done=%b want 00", {busy, done}); end
        op = 2'd3; in1 = $urandom; in2 = '0; start = 1'b1;
        step();
        start = 1'b0; flush = 1'b1;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fin_flush_done got %b want 0", done); end
        step();
        flush = 1'b0;
        step();
        checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL fin_flush_hold got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL fin_flush_div_zero got %b want 1", div_zero); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] eh, el, b;
        int lat;
        op = 2'd3; in1 = $urandom; b = $urandom >> $urandom_range(0, 31); in2 = (b == '0) ? 32'd1 : b;
        start = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            model(op, in1, in2, eh, el);
            lat = -1;
            for (int c = 1; c <= W + 8; c++) begin
                if (done) begin lat = c; break; end
                step();
            end
            checks++; if (lat !== W + 1) begin errors++; $display("FAIL b2b_latency op#%0d got %0d want %0d", k, lat, W + 1); end
            step();
            checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_done_width op#%0d got busy,done=%b want 00", k, {busy, done}); end
            checks++; if ({hi, lo} !== {eh, el}) begin errors++; $display("FAIL b2b_result op#%0d got %h_%h want %h_%h", k, hi, lo, eh, el); end
            in1 = $urandom; b = $urandom >> $urandom_range(0, 31); in2 = (b == '0) ? 32'd7 : b;
            step();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_relaunch op#%0d got busy=%b want 1", k, busy); end
        end
        start = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
